// File: rtl/nios_system_nios2_cpu_div_pkg.sv
// Shared types and constants for the Nios II multi-cycle divider cell.
package nios_system_nios2_cpu_div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    // 0x80000000 maps onto itself, which reads correctly as unsigned 2^31.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/nios_system_nios2_cpu_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract if it fits.
module nios_system_nios2_cpu_div_step
    import nios_system_nios2_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // The running remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        shifted  = {rem_in[WIDTH-1:0], dividend_bit};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        quot_bit = ~diff[WIDTH+1];
        rem_out  = quot_bit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/nios_system_nios2_cpu_div_cell.sv
// Fixed-latency (34 cycle) signed/unsigned restoring divider for the Nios II M stage.
module nios_system_nios2_cpu_div_cell
    import nios_system_nios2_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             E_flush,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_by_zero
);

    div_state_e       state, state_next;
    logic             accept, finish;
    logic [5:0]       count;
    logic [WIDTH-1:0] src1_q, dvd_q, dvs_q;
    logic [WIDTH:0]   rem_q, rem_next;
    logic             signed_q, q_neg, r_neg, q_bit;
    logic [WIDTH-1:0] quot_raw;

    nios_system_nios2_cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem_q),
        .divisor      (dvs_q),
        .dividend_bit (dvd_q[WIDTH-1]),
        .rem_out      (rem_next),
        .quot_bit     (q_bit)
    );

    assign quot_raw = {dvd_q[WIDTH-2:0], q_bit};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            // FIX accepts a start too, which is what makes back-to-back issue 34 cycles.
            IDLE, FIX: begin
                state_next = IDLE;
                if (E_div_start) begin
                    accept     = 1'b1;
                    state_next = PREP;
                end
            end
            PREP: state_next = ITER;
            ITER: begin
                if (count == 6'd1) begin
                    finish     = 1'b1;
                    state_next = FIX;
                end
            end
            default: state_next = IDLE;
        endcase
        if (E_flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            count         <= '0;
            src1_q        <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            signed_q      <= 1'b0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            M_div_busy    <= 1'b0;
            M_div_done    <= 1'b0;
            M_div_quot    <= '0;
            M_div_rem     <= '0;
            M_div_by_zero <= 1'b0;
        end else begin
            state      <= state_next;
            M_div_done <= finish;

            if (accept) begin
                M_div_busy <= 1'b1;
                src1_q     <= E_src1;
                dvd_q      <= E_src1;
                dvs_q      <= E_src2;
                signed_q   <= E_div_signed;
            end else if (finish || E_flush) begin
                M_div_busy <= 1'b0;
            end

            case (state)
                PREP: begin
                    dvd_q <= abs_val(dvd_q, signed_q);
                    dvs_q <= abs_val(dvs_q, signed_q);
                    q_neg <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg <= signed_q & dvd_q[WIDTH-1];
                    rem_q <= '0;
                    count <= 6'(ITER_COUNT);
                end
                ITER: begin
                    rem_q <= rem_next;
                    dvd_q <= quot_raw;
                    count <= count - 6'd1;
                end
                default: ;
            endcase

            // The last step and the sign fix-up land together so done and the result appear in the same cycle.
            if (finish) begin
                if (dvs_q == '0) begin
                    M_div_quot    <= '1;
                    M_div_rem     <= src1_q;
                    M_div_by_zero <= 1'b1;
                end else begin
                    M_div_quot    <= q_neg ? -quot_raw : quot_raw;
                    M_div_rem     <= r_neg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
                    M_div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
